// File: rtl/val2_shift_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// val2_shift_sequencer
//
// Multi-cycle computation of the EXE-stage val2 operand. It produces the memory
// offset, the rotated immediate or the shifted Rm, one of these per request.
// A working register moves by at most STEP bits per cycle. This keeps the
// 32-bit barrel shifter off the critical path. The stall unit holds the
// pipeline while busy is high.
//
// Parameters
//   STEP            bits shifted per SHIFT cycle (1, 2, 4 or 8)
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-low reset
//   start           request a new computation; accepted only when idle
//   flush           synchronous abort back to IDLE, no done pulse
//   mem_inst        LDR/STR: val2 = sign-extended 12-bit offset
//   imm             data-processing immediate (ignored when mem_inst=1)
//   val_rm          Rm register value
//   shifter_operand instruction bits [11:0]
//   val2            result; valid with done, held until the next accepted start
//   busy            high from the accepting edge through the done cycle
//   done            one-cycle completion pulse
//
// Timing
//   E0 is the accepting edge. The FSM then spends ceil(count/STEP) cycles in
//   SHIFT and one cycle in DONE. done and busy are registered, so the done
//   pulse appears in the cycle after E(1+ceil(count/STEP)). busy stays high
//   through that cycle, and the FSM is already back in IDLE then. A start
//   seen during the done cycle is therefore ignored. The requester
//   re-asserts start once busy has dropped.
// -----------------------------------------------------------------------------
module val2_shift_sequencer #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic        mem_inst,
  input  logic        imm,
  input  logic [31:0] val_rm,
  input  logic [11:0] shifter_operand,
  output logic [31:0] val2,
  output logic        busy,
  output logic        done
);

  localparam int DATA_W = 32;

  // Per-cycle shift amount. It fits the 5-bit count because STEP <= 8.
  localparam logic [4:0] STEP_AMT = 5'(STEP);

  // Shift kinds, encoded as in shifter_operand[6:5].
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT              state;
  stateT              nextState;

  logic [4:0]         count;
  logic [1:0]         shType;

  logic               accept;
  logic [DATA_W-1:0]  loadVal;
  logic [4:0]         loadCount;
  logic [1:0]         loadType;

  logic [4:0]         stepAmt;
  logic [4:0]         countAfter;
  logic [DATA_W-1:0]  shifted;

  logic               busyNext;
  logic               doneNext;

  // One partial shift step of n bits (n <= STEP). ASR uses an explicitly
  // signed view so the sign bit replicates. ROR ORs the wrapped-around low
  // bits back in from the top.
  function automatic logic [DATA_W-1:0] shiftStep(
    input logic [DATA_W-1:0] v,
    input logic [1:0]        kind,
    input logic [4:0]        n
  );
    logic signed [DATA_W-1:0] sv;
    logic [5:0]               backAmt;
    logic [DATA_W-1:0]        r;
    sv      = v;
    backAmt = 6'd32 - {1'b0, n};
    case (kind)
      SH_LSL:  r = v << n;
      SH_LSR:  r = v >> n;
      SH_ASR:  r = $unsigned(sv >>> n);
      default: r = (v >> n) | (v << backAmt);
    endcase
    return r;
  endfunction

  // Request decode. The request is accepted only when truly idle. The
  // done-cycle check is the busy term, because the FSM is back in IDLE while
  // busy is still high.
  assign accept = (state == IDLE) && start && !flush && !busy;

  always_comb begin
    loadVal   = val_rm;
    loadCount = shifter_operand[11:7];
    loadType  = shifter_operand[6:5];
    if (mem_inst) begin
      loadVal   = {{20{shifter_operand[11]}}, shifter_operand};
      loadCount = 5'd0;
      loadType  = SH_LSL;
    end else if (imm) begin
      loadVal   = {24'd0, shifter_operand[7:0]};
      loadCount = {shifter_operand[11:8], 1'b0};
      loadType  = SH_ROR;
    end
  end

  // Per-cycle step: n = min(count, STEP).
  always_comb begin
    stepAmt    = (count < STEP_AMT) ? count : STEP_AMT;
    countAfter = count - stepAmt;
    shifted    = shiftStep(val2, shType, stepAmt);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next-state logic. flush overrides everything, including the DONE
  // pulse.
  always_comb begin
    nextState = state;
    if (flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            nextState = (loadCount == 5'd0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (countAfter == 5'd0) begin
            nextState = DONE;
          end
        end
        DONE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // FSM outputs, computed one cycle ahead and registered below. busy covers
  // the accepting edge through the done cycle.
  always_comb begin
    busyNext = 1'b0;
    doneNext = 1'b0;
    if (!flush) begin
      doneNext = (state == DONE);
      busyNext = (nextState != IDLE) || (state == DONE);
    end
  end

  // Working register, shift control and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val2   <= '0;
      count  <= '0;
      shType <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= busyNext;
      done <= doneNext;
      if (accept) begin
        val2   <= loadVal;
        count  <= loadCount;
        shType <= loadType;
      end else if ((state == SHIFT) && !flush) begin
        val2  <= shifted;
        count <= countAfter;
      end
    end
  end

  // Structural invariants of the sequencer.
  assert property (@(posedge clk) disable iff (!rst) done |-> busy);
  assert property (@(posedge clk) disable iff (!rst) (state == SHIFT) |-> (count != 5'd0));

endmodule

// File: tb/tb_val2_shift_sequencer.sv
`timescale 1ns/1ps
module tb_val2_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic        mem_inst;
  logic        imm;
  logic [31:0] val_rm;
  logic [11:0] so;

  logic [31:0] val2A, val2B;
  logic        busyA, busyB, doneA, doneB;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  val2_shift_sequencer #(.STEP(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .mem_inst(mem_inst),
    .imm(imm), .val_rm(val_rm), .shifter_operand(so),
    .val2(val2A), .busy(busyA), .done(doneA)
  );

  val2_shift_sequencer #(.STEP(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .mem_inst(mem_inst),
    .imm(imm), .val_rm(val_rm), .shifter_operand(so),
    .val2(val2B), .busy(busyB), .done(doneB)
  );

  typedef struct {
    logic        m;
    logic        im;
    logic [31:0] rm;
    logic [11:0] s;
    logic [31:0] expVal;
    int          cnt;
  } vecT;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: whole-amount shift with plain arithmetic.
  function automatic logic [31:0] rorRef(input logic [31:0] v, input int amt);
    logic [63:0] d;
    d = {v, v} >> amt;
    return d[31:0];
  endfunction

  function automatic int refCount(input logic m, input logic im, input logic [11:0] s);
    if (m) return 0;
    if (im) return 2 * int'(s[11:8]);
    return int'(s[11:7]);
  endfunction

  function automatic logic [31:0] refVal(input logic m, input logic im,
                                         input logic [31:0] rm, input logic [11:0] s);
    logic signed [31:0] sr;
    int amt;
    amt = refCount(m, im, s);
    if (m) return {{20{s[11]}}, s};
    if (im) return rorRef({24'd0, s[7:0]}, amt);
    sr = rm;
    case (s[6:5])
      2'b00:   return rm << amt;
      2'b01:   return rm >> amt;
      2'b10:   return $unsigned(sr >>> amt);
      default: return rorRef(rm, amt);
    endcase
  endfunction

  task automatic scramble();
    mem_inst = 1'($urandom);
    imm      = 1'($urandom);
    val_rm   = $urandom;
    so       = 12'($urandom);
  endtask

  // One complete transaction, checked on both step sizes.
  task automatic doOp(input string tag, input logic m, input logic im,
                      input logic [31:0] rm, input logic [11:0] s,
                      input logic [31:0] expVal, input int cnt);
    int lat1, lat4;
    int firstA, firstB, pulsesA, pulsesB, badA, badB;
    lat1 = 1 + cnt;
    lat4 = 1 + (cnt + 3) / 4;
    firstA = -1; firstB = -1; pulsesA = 0; pulsesB = 0; badA = 0; badB = 0;
    @(negedge clk);
    mem_inst = m; imm = im; val_rm = rm; so = s; start = 1'b1; flush = 1'b0;
    for (int k = 0; k <= lat1 + 1; k++) begin
      if (k > 0) begin
        @(negedge clk);
        start = (k < lat4) ? 1'($urandom) : 1'b0;
        scramble();
      end
      @(posedge clk); #1;
      if (k == 0) begin
        start = 1'b0;
        scramble();
      end
      if (doneA) begin pulsesA++; if (firstA < 0) firstA = k; end
      if (doneB) begin pulsesB++; if (firstB < 0) firstB = k; end
      if (busyA !== (k <= lat1)) badA++;
      if (doneA !== (k == lat1)) badA++;
      if (busyB !== (k <= lat4)) badB++;
      if (doneB !== (k == lat4)) badB++;
    end
    chk({tag, " val2 step1"}, val2A, expVal);
    chk({tag, " val2 step4"}, val2B, expVal);
    chk({tag, " done edge step1"}, 32'(firstA), 32'(lat1));
    chk({tag, " done edge step4"}, 32'(firstB), 32'(lat4));
    chk({tag, " done pulses step1"}, 32'(pulsesA), 32'd1);
    chk({tag, " done pulses step4"}, 32'(pulsesB), 32'd1);
    chk({tag, " busy/done profile step1"}, 32'(badA), 32'd0);
    chk({tag, " busy/done profile step4"}, 32'(badB), 32'd0);
  endtask

  vecT vecs[13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic m, im;
    logic [31:0] rm;
    logic [11:0] s;

    vecs[0]  = '{1'b0, 1'b1, 32'h0,        12'h4FF, 32'hFF000000, 8};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,        12'hFFC, 32'hFFFFFFFC, 0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        12'h7FC, 32'h000007FC, 0};
    vecs[3]  = '{1'b0, 1'b0, 32'h80000000, 12'h240, 32'hF8000000, 4};
    vecs[4]  = '{1'b0, 1'b0, 32'h80000000, 12'h220, 32'h08000000, 4};
    vecs[5]  = '{1'b0, 1'b0, 32'h00000001, 12'h0E0, 32'h80000000, 1};
    vecs[6]  = '{1'b0, 1'b0, 32'h12345678, 12'h000, 32'h12345678, 0};
    vecs[7]  = '{1'b0, 1'b0, 32'h80000000, 12'hFA0, 32'h00000001, 31};
    vecs[8]  = '{1'b0, 1'b1, 32'h0,        12'h0AB, 32'h000000AB, 0};
    vecs[9]  = '{1'b1, 1'b1, 32'h0,        12'h8AB, 32'hFFFFF8AB, 0};
    vecs[10] = '{1'b0, 1'b0, 32'h7FFFFFFF, 12'hFC0, 32'h00000000, 31};
    vecs[11] = '{1'b0, 1'b0, 32'h80000001, 12'hFE0, 32'h00000003, 31};
    vecs[12] = '{1'b0, 1'b1, 32'h0,        12'hF01, 32'h00000004, 30};

    rst = 1'b0; start = 1'b0; flush = 1'b0;
    mem_inst = 1'b0; imm = 1'b0; val_rm = 32'h0; so = 12'h0;
    #12;
    chk("reset val2 step1", val2A, 32'h0);
    chk("reset val2 step4", val2B, 32'h0);
    chk("reset busy", {30'd0, busyA, busyB}, 32'h0);
    chk("reset done", {30'd0, doneA, doneB}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      doOp($sformatf("vec%0d", i), vecs[i].m, vecs[i].im, vecs[i].rm, vecs[i].s,
           vecs[i].expVal, vecs[i].cnt);
    end

    for (int i = 0; i < 40; i++) begin
      m  = ($urandom_range(0, 3) == 0);
      im = 1'($urandom);
      rm = $urandom;
      s  = 12'($urandom);
      doOp($sformatf("rand%0d", i), m, im, rm, s, refVal(m, im, rm, s), refCount(m, im, s));
    end

    // start during the done cycle is ignored; it is accepted once busy drops
    @(negedge clk);
    mem_inst = 1'b1; imm = 1'b0; so = 12'hFFC; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("done-cycle done", {31'd0, doneA}, 32'd1);
    @(negedge clk);
    mem_inst = 1'b1; so = 12'h123; start = 1'b1;
    @(posedge clk); #1;
    chk("start in done cycle ignored", {30'd0, busyA, busyB}, 32'h0);
    @(posedge clk); #1;
    chk("start re-asserted accepted", {30'd0, busyA, busyB}, 32'h3);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("re-asserted op done", {30'd0, doneA, doneB}, 32'h3);
    chk("re-asserted op val2", val2A, 32'h00000123);
    repeat (3) @(posedge clk);

    // flush mid-shift: no done pulse, busy drops after the flushing edge
    @(negedge clk);
    mem_inst = 1'b0; imm = 1'b0; val_rm = 32'h80000000; so = 12'hFA0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush busy", {30'd0, busyA, busyB}, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (doneA) pulses++;
      if (doneB) pulses++;
    end
    chk("flush no done", 32'(pulses), 32'd0);

    // asynchronous reset mid-shift
    @(negedge clk);
    val_rm = 32'h80000000; so = 12'hFA0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async reset busy", {30'd0, busyA, busyB}, 32'h0);
    chk("async reset done", {30'd0, doneA, doneB}, 32'h0);
    chk("async reset val2 step1", val2A, 32'h0);
    chk("async reset val2 step4", val2B, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    doOp("after reset", 1'b0, 1'b0, 32'h00000F00, 12'h200, 32'h0000F000, 4);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
